// File: rtl/alu_rr_arbiter_pkg.sv
// Shared definitions for the ALU round-robin arbiter: ALU control codes,
// branch-flag meanings and the arbiter state encoding.
package alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_SLT = 3'd5;

    // Meaning of the ALU EQ flag when codes 0-3 are used as branch compares
    localparam logic [2:0] BR_EQ = 3'd0;
    localparam logic [2:0] BR_NE = 3'd1;
    localparam logic [2:0] BR_LT = 3'd2;
    localparam logic [2:0] BR_GE = 3'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    function automatic int unsigned id_width(input int unsigned num_req);
        return (num_req > 32'd1) ? $clog2(num_req) : 32'd1;
    endfunction

endpackage

// File: rtl/alu_rr_arbiter_if.sv
// Bundle of requester, ALU and response signals around the shared-ALU arbiter.
// The slave modport is the arbiter; the master modport is its environment.
interface alu_rr_arbiter_if
    import alu_pkg::*;
#(
    parameter int NUM_REQ       = 2,
    parameter int CONTROL_WIDTH = 3,
    parameter int DATA_WIDTH    = 32,
    parameter int ID_WIDTH      = int'(id_width(NUM_REQ))
);

    logic [NUM_REQ-1:0]               req_valid;
    logic [NUM_REQ-1:0]               req_ready;
    logic [NUM_REQ*DATA_WIDTH-1:0]    req_op1;
    logic [NUM_REQ*DATA_WIDTH-1:0]    req_op2;
    logic [NUM_REQ*CONTROL_WIDTH-1:0] req_ctrl;

    logic [DATA_WIDTH-1:0]            alu_op1;
    logic [DATA_WIDTH-1:0]            alu_op2;
    logic [CONTROL_WIDTH-1:0]         alu_ctrl;
    logic [DATA_WIDTH-1:0]            alu_result;
    logic                             alu_eq;

    logic                             rsp_valid;
    logic                             rsp_ready;
    logic [ID_WIDTH-1:0]              rsp_id;
    logic [DATA_WIDTH-1:0]            rsp_result;
    logic                             rsp_eq;

    modport slave (
        input  req_valid, req_op1, req_op2, req_ctrl,
        input  alu_result, alu_eq, rsp_ready,
        output req_ready, alu_op1, alu_op2, alu_ctrl,
        output rsp_valid, rsp_id, rsp_result, rsp_eq
    );

    modport master (
        output req_valid, req_op1, req_op2, req_ctrl,
        output alu_result, alu_eq, rsp_ready,
        input  req_ready, alu_op1, alu_op2, alu_ctrl,
        input  rsp_valid, rsp_id, rsp_result, rsp_eq
    );

endinterface

// File: rtl/alu_rr_arbiter_rr_picker.sv
// Combinational round-robin picker: scans from the slot after ptr_i upward
// with wrap and returns the first requester as one-hot, index and any flag.
module rr_picker #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    logic [IW-1:0] cand_s;
    logic          hit_s;

    // Priority scan; once any_o is set later candidates can no longer hit
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        cand_s  = '0;
        hit_s   = 1'b0;
        for (int k = 1; k <= N; k++) begin
            cand_s          = IW'((int'(ptr_i) + k) % N);
            hit_s           = !any_o && req_i[cand_s];
            grant_o[cand_s] = grant_o[cand_s] | hit_s;
            idx_o           = hit_s ? cand_s : idx_o;
            any_o           = any_o | hit_s;
        end
    end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one combinational ALU among NUM_REQ requesters;
// one operation in flight, response held in a slot until the consumer takes it.
module alu_rr_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ       = 2,
    parameter int CONTROL_WIDTH = 3,
    parameter int DATA_WIDTH    = 32,
    parameter int ID_WIDTH      = int'(id_width(NUM_REQ))
) (
    input logic             clk,
    input logic             rst,
    alu_rr_arbiter_if.slave arb_if
);

    arb_state_t               state_q, state_d;
    logic [ID_WIDTH-1:0]      rr_ptr_q, rr_ptr_d;
    logic [ID_WIDTH-1:0]      pend_id_q, pend_id_d;
    logic [DATA_WIDTH-1:0]    alu_op1_q, alu_op1_d;
    logic [DATA_WIDTH-1:0]    alu_op2_q, alu_op2_d;
    logic [CONTROL_WIDTH-1:0] alu_ctrl_q, alu_ctrl_d;
    logic                     rsp_valid_q, rsp_valid_d;
    logic [ID_WIDTH-1:0]      rsp_id_q, rsp_id_d;
    logic [DATA_WIDTH-1:0]    rsp_result_q, rsp_result_d;
    logic                     rsp_eq_q, rsp_eq_d;

    logic                     can_accept_s;
    logic                     fire_s;
    logic                     pick_any_s;
    logic [NUM_REQ-1:0]       pick_grant_s;
    logic [ID_WIDTH-1:0]      pick_idx_s;
    logic [DATA_WIDTH-1:0]    sel_op1_s;
    logic [DATA_WIDTH-1:0]    sel_op2_s;
    logic [CONTROL_WIDTH-1:0] sel_ctrl_s;

    rr_picker #(
        .N  (NUM_REQ),
        .IW (ID_WIDTH)
    ) u_picker (
        .req_i   (arb_if.req_valid),
        .ptr_i   (rr_ptr_q),
        .grant_o (pick_grant_s),
        .idx_o   (pick_idx_s),
        .any_o   (pick_any_s)
    );

    // The slot frees up in the same cycle the consumer drains it, allowing back-to-back ops
    assign can_accept_s     = (state_q == IDLE) || ((state_q == RESP) && arb_if.rsp_ready);
    assign fire_s           = can_accept_s && pick_any_s;
    assign arb_if.req_ready = can_accept_s ? pick_grant_s : {NUM_REQ{1'b0}};

    // Operand mux selecting the winning requester's slices
    always_comb begin
        sel_op1_s  = '0;
        sel_op2_s  = '0;
        sel_ctrl_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_op1_s  = (pick_idx_s == ID_WIDTH'(i)) ?
                         arb_if.req_op1[i*DATA_WIDTH +: DATA_WIDTH] : sel_op1_s;
            sel_op2_s  = (pick_idx_s == ID_WIDTH'(i)) ?
                         arb_if.req_op2[i*DATA_WIDTH +: DATA_WIDTH] : sel_op2_s;
            sel_ctrl_s = (pick_idx_s == ID_WIDTH'(i)) ?
                         arb_if.req_ctrl[i*CONTROL_WIDTH +: CONTROL_WIDTH] : sel_ctrl_s;
        end
    end

    // Next-state logic for FSM, operand registers and response slot
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        pend_id_d    = pend_id_q;
        alu_op1_d    = alu_op1_q;
        alu_op2_d    = alu_op2_q;
        alu_ctrl_d   = alu_ctrl_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_eq_d     = rsp_eq_q;

        case (state_q)
            IDLE: begin
                if (fire_s) begin
                    state_d = EXEC;
                end else begin
                    state_d = IDLE;
                end
            end
            EXEC: begin
                rsp_result_d = arb_if.alu_result;
                rsp_eq_d     = arb_if.alu_eq;
                rsp_id_d     = pend_id_q;
                rsp_valid_d  = 1'b1;
                state_d      = RESP;
            end
            RESP: begin
                if (arb_if.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = fire_s ? EXEC : IDLE;
                end else begin
                    state_d     = RESP;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase

        if (fire_s) begin
            alu_op1_d  = sel_op1_s;
            alu_op2_d  = sel_op2_s;
            alu_ctrl_d = sel_ctrl_s;
            pend_id_d  = pick_idx_s;
            rr_ptr_d   = pick_idx_s;
        end else begin
            pend_id_d  = pend_id_q;
        end
    end

    // State and datapath registers; pointer resets to the last slot so requester 0 wins first
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            rr_ptr_q     <= ID_WIDTH'(NUM_REQ - 1);
            pend_id_q    <= '0;
            alu_op1_q    <= '0;
            alu_op2_q    <= '0;
            alu_ctrl_q   <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
            rsp_eq_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            pend_id_q    <= pend_id_d;
            alu_op1_q    <= alu_op1_d;
            alu_op2_q    <= alu_op2_d;
            alu_ctrl_q   <= alu_ctrl_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_eq_q     <= rsp_eq_d;
        end
    end

    assign arb_if.alu_op1    = alu_op1_q;
    assign arb_if.alu_op2    = alu_op2_q;
    assign arb_if.alu_ctrl   = alu_ctrl_q;
    assign arb_if.rsp_valid  = rsp_valid_q;
    assign arb_if.rsp_id     = rsp_id_q;
    assign arb_if.rsp_result = rsp_result_q;
    assign arb_if.rsp_eq     = rsp_eq_q;

endmodule
